// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, screen-mode encoding and total-period helper
// for the scan engine and its testbench.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_MEM_LAT  = 2;
    localparam int DEF_MODE_W   = 3;
    localparam int DEF_DATA_W   = 24;

    typedef enum logic [2:0] {
        MODE_TEXT     = 3'd0,
        MODE_GFX_LO   = 3'd1,
        MODE_GFX_HI   = 3'd2,
        MODE_TILE     = 3'd3,
        MODE_SPRITE   = 3'd4,
        MODE_MIXED    = 3'd5,
        MODE_DEBUG    = 3'd6,
        MODE_BLANK    = 3'd7
    } vga_mode_e;

    localparam vga_mode_e MODE_RESET = MODE_TEXT;

    // Full line or frame period from its active, porch and sync widths.
    function automatic int scan_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable shift pipeline of DEPTH registers; also exposes the low TAP_W
// bits one stage before the end so a consumer can register alongside it.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter int               TAP_W     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [TAP_W-1:0] tap_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] chain [DEPTH+1];

    assign chain[0] = data_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_q;

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    stage_q <= RESET_VAL;
                end else begin
                    stage_q <= chain[gi];
                end
            end

            assign chain[gi+1] = stage_q;
        end
    endgenerate

    assign tap_o  = chain[DEPTH-1][TAP_W-1:0];
    assign data_o = chain[DEPTH];

endmodule

// File: rtl/vga_scan_engine.sv
// VGA raster scanner: h/v counters, linear frame-buffer address generation,
// sync/blank pipeline matched to memory latency, and frame-level pulses.
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MEM_LAT  = DEF_MEM_LAT,
    parameter int MODE_W   = DEF_MODE_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic [MODE_W-1:0] iModeReq,
    output logic [MODE_W-1:0] oMode,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oAddrValid,
    input  logic [DATA_W-1:0] iPixel,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [DATA_W-1:0] oRGB,
    output logic              oFrameStart,
    output logic              oSnapshot
);

    localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DLY     = MEM_LAT + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
            $error("vga_scan_engine: H_ACTIVE*V_ACTIVE does not fit in ADDR_W bits");
        end
        if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_mem_lat
            $error("vga_scan_engine: MEM_LAT must be within 1..8");
        end
    endgenerate

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MODE_W-1:0] mode_q;
    logic [DATA_W-1:0] rgb_q;
    // Low during reset and for the release edge, so counting starts one clock later.
    logic              run_q;

    logic h_last, v_last;
    logic active_raw, hs_raw, vs_raw;
    logic frame_start, snapshot;
    logic [2:0] dl_out;
    logic       active_tap;

    always_comb begin
        h_last      = (h_q == H_LAST);
        v_last      = (v_q == V_LAST);
        active_raw  = run_q && (h_q < H_ACT_C) && (v_q < V_ACT_C);
        hs_raw      = !((h_q >= HS_BEG) && (h_q < HS_END));
        vs_raw      = !((v_q >= VS_BEG) && (v_q < VS_END));
        frame_start = run_q && (h_q == '0) && (v_q == '0);
        snapshot    = run_q && (h_q == '0) && (v_q == V_ACT_C);
    end

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        addr_d = addr_q;
        if (run_q) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            // Running address replaces v*H_ACTIVE+h; it simply holds through blanking.
            if (h_last && v_last) begin
                addr_d = '0;
            end else if (active_raw) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            h_q    <= '0;
            v_q    <= '0;
            addr_q <= '0;
            mode_q <= MODE_W'(MODE_RESET);
            run_q  <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            addr_q <= addr_d;
            run_q  <= 1'b1;
            if (frame_start) begin
                mode_q <= iModeReq;
            end
        end
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (DLY),
        .TAP_W     (1),
        .RESET_VAL (3'b110)
    ) u_sync_dly (
        .clk_i   (iVGA_CLK),
        .rst_n_i (iRST_n),
        .data_i  ({hs_raw, vs_raw, active_raw}),
        .tap_o   (active_tap),
        .data_o  (dl_out)
    );

    // Colour is captured on the stage where the active flag lines up with iPixel.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= active_tap ? iPixel : '0;
        end
    end

    assign oMode       = mode_q;
    assign oAddr       = addr_q;
    assign oAddrValid  = active_raw;
    assign oHS         = dl_out[2];
    assign oVS         = dl_out[1];
    assign oBLANK_n    = dl_out[0];
    assign oRGB        = rgb_q;
    assign oFrameStart = frame_start;
    assign oSnapshot   = snapshot;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine on a shrunken 8x4 raster (16x9 totals)
// with a two-clock latency pixel memory model.
module tb_vga_scan_engine;

    localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 2;
    localparam int LAT = 2, AW = 5, MW = 3, DW = 24;
    localparam int HT = 16, VT = 9, FT = 144, PIPE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW-1:0] mode_req = '0;
    logic [MW-1:0] mode;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic [DW-1:0] pixel;
    logic          hs, vs, blank_n;
    logic [DW-1:0] rgb;
    logic          fs, snap;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    always #5 clk = ~clk;

    vga_scan_engine #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
        .ADDR_W (AW), .MEM_LAT (LAT), .MODE_W (MW), .DATA_W (DW)
    ) dut (
        .iVGA_CLK    (clk),
        .iRST_n      (rst_n),
        .iModeReq    (mode_req),
        .oMode       (mode),
        .oAddr       (addr),
        .oAddrValid  (addr_valid),
        .iPixel      (pixel),
        .oHS         (hs),
        .oVS         (vs),
        .oBLANK_n    (blank_n),
        .oRGB        (rgb),
        .oFrameStart (fs),
        .oSnapshot   (snap)
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return {3'b101, a, ~a, 3'b010, a, 3'b000};
    endfunction

    // Pixel memory: answers an address LAT clocks later.
    logic [AW-1:0] ap1, ap2;
    always @(posedge clk) begin
        ap1 <= addr;
        ap2 <= ap1;
    end
    assign pixel = pix(ap2);

    // Expected {fs,snap,valid,addr,hs,vs,blank_n,rgb} at cycle k after release.
    function automatic logic [34:0] expect_at(input int k);
        int h, v, m, hm, vm, idx;
        logic e_fs, e_sn, e_av, e_hs, e_vs, e_bl;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_rgb;
        h    = k % HT;
        v    = (k / HT) % VT;
        e_fs = (h == 0 && v == 0);
        e_sn = (h == 0 && v == VA);
        e_av = (h < HA && v < VA);
        idx  = (v < VA) ? v * HA + ((h < HA) ? h : HA) : HA * VA;
        e_ad = idx[AW-1:0];
        e_hs = 1'b1;
        e_vs = 1'b1;
        e_bl = 1'b0;
        e_rgb = '0;
        m = k - PIPE;
        if (m >= 0) begin
            hm   = m % HT;
            vm   = (m / HT) % VT;
            e_hs = !(hm >= HA + HF && hm < HA + HF + HSY);
            e_vs = !(vm >= VA + VF && vm < VA + VF + VSY);
            e_bl = (hm < HA && vm < VA);
            if (e_bl) begin
                idx   = vm * HA + hm;
                e_rgb = pix(idx[AW-1:0]);
            end
        end
        return {e_fs, e_sn, e_av, e_ad, e_hs, e_vs, e_bl, e_rgb};
    endfunction

    function automatic logic [34:0] observed();
        return {fs, snap, addr_valid, addr, hs, vs, blank_n, rgb};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        next_cycle();
        n = 0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mode_req = 3'd6;
        repeat (4) next_cycle();
        total++; if (fs !== 1'b0)         begin bad++; $display("FAIL reset_fs got=%0b want=0", fs); end
        total++; if (snap !== 1'b0)       begin bad++; $display("FAIL reset_snap got=%0b want=0", snap); end
        total++; if (addr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", addr_valid); end
        total++; if (addr !== 5'd0)       begin bad++; $display("FAIL reset_addr got=%0d want=0", addr); end
        total++; if (mode !== 3'd0)       begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
        total++; if (hs !== 1'b1)         begin bad++; $display("FAIL reset_hs got=%0b want=1", hs); end
        total++; if (vs !== 1'b1)         begin bad++; $display("FAIL reset_vs got=%0b want=1", vs); end
        total++; if (blank_n !== 1'b0)    begin bad++; $display("FAIL reset_blank got=%0b want=0", blank_n); end
        total++; if (rgb !== 24'd0)       begin bad++; $display("FAIL reset_rgb got=%h want=0", rgb); end
        $display("test_reset: done");
    endtask

    task automatic test_scan();
        int last_hs_fall, last_vs_fall, hs_cnt, vs_low, snaps;
        logic prev_hs, prev_vs, seen31, wrapped;
        logic [34:0] e_vec, a_vec;
        mode_req = 3'd1;
        release_reset();
        last_hs_fall = -1; last_vs_fall = -1;
        hs_cnt = 0; vs_low = 0; snaps = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; seen31 = 1'b0; wrapped = 1'b0;
        for (int k = 0; k < 2 * FT; k++) begin
            if (k > 0) next_cycle();
            e_vec = expect_at(n);
            a_vec = observed();
            total++;
            if (a_vec !== e_vec) begin
                bad++;
                $display("FAIL scan n=%0d got=%h want=%h", n, a_vec, e_vec);
            end
            if (prev_hs && !hs) begin
                if (last_hs_fall >= 0) begin
                    total++;
                    if (n - last_hs_fall !== HT) begin
                        bad++;
                        $display("FAIL hs_period got=%0d want=%0d", n - last_hs_fall, HT);
                    end
                end
                last_hs_fall = n;
                hs_cnt++;
            end
            if (prev_vs && !vs) begin
                if (last_vs_fall >= 0) begin
                    total++;
                    if (hs_cnt !== VT) begin
                        bad++;
                        $display("FAIL lines_per_frame got=%0d want=%0d", hs_cnt, VT);
                    end
                end
                last_vs_fall = n;
                hs_cnt = 0;
            end
            if (!vs) vs_low++;
            if (snap) snaps++;
            if (addr_valid && addr == 5'd31) seen31 = 1'b1;
            if (addr_valid && addr == 5'd0 && seen31) wrapped = 1'b1;
            prev_hs = hs;
            prev_vs = vs;
        end
        total++; if (vs_low !== 2 * VSY * HT) begin bad++; $display("FAIL vs_low_clocks got=%0d want=%0d", vs_low, 2 * VSY * HT); end
        total++; if (snaps !== 2)             begin bad++; $display("FAIL snapshot_count got=%0d want=2", snaps); end
        total++; if (seen31 !== 1'b1)         begin bad++; $display("FAIL last_addr_31 got=%0b want=1", seen31); end
        total++; if (wrapped !== 1'b1)        begin bad++; $display("FAIL addr_wrap got=%0b want=1", wrapped); end
        $display("test_scan: two frames scanned, last n=%0d", n);
    endtask

    task automatic test_latency();
        int first_valid, first_blank;
        rst_n = 1'b0;
        repeat (2) next_cycle();
        release_reset();
        first_valid = -1;
        first_blank = -1;
        for (int k = 0; k < 40 && first_blank < 0; k++) begin
            if (k > 0) next_cycle();
            if (addr_valid && first_valid < 0) first_valid = n;
            if (blank_n && first_blank < 0) first_blank = n;
        end
        total++;
        if (first_valid < 0 || first_blank < 0 || first_blank - first_valid !== PIPE) begin
            bad++;
            $display("FAIL blank_latency got=%0d want=%0d (valid@%0d blank@%0d)",
                     first_blank - first_valid, PIPE, first_valid, first_blank);
        end
        $display("test_latency: valid@%0d blank@%0d", first_valid, first_blank);
    endtask

    task automatic test_mode();
        rst_n    = 1'b0;
        mode_req = 3'd1;
        repeat (2) next_cycle();
        release_reset();
        next_cycle();
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL mode_load got=%0d want=1", mode); end
        while (n < 2 * HT + 5) next_cycle();
        mode_req = 3'd5;
        while (n < FT - 1) next_cycle();
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL mode_hold got=%0d want=1", mode); end
        next_cycle();
        total++; if (fs !== 1'b1)   begin bad++; $display("FAIL mode_fs got=%0b want=1", fs); end
        total++; if (mode !== 3'd1) begin bad++; $display("FAIL mode_at_fs got=%0d want=1", mode); end
        next_cycle();
        total++; if (mode !== 3'd5) begin bad++; $display("FAIL mode_switch got=%0d want=5", mode); end
        mode_req = 3'd2;
        while (n < FT + 60) next_cycle();
        total++; if (mode !== 3'd5) begin bad++; $display("FAIL mode_ignore got=%0d want=5", mode); end
        $display("test_mode: mode=%0d at n=%0d", mode, n);
    endtask

    task automatic test_reset_mid();
        logic [34:0] e_vec, a_vec;
        rst_n = 1'b0;
        repeat (2) next_cycle();
        release_reset();
        while (n < 2 * HT + 5) next_cycle();
        rst_n = 1'b0;
        repeat (3) next_cycle();
        e_vec = {1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 24'd0};
        a_vec = observed();
        total++; if (a_vec !== e_vec) begin bad++; $display("FAIL midreset_outputs got=%h want=%h", a_vec, e_vec); end
        total++; if (mode !== 3'd0)   begin bad++; $display("FAIL midreset_mode got=%0d want=0", mode); end
        release_reset();
        total++; if (fs !== 1'b1)     begin bad++; $display("FAIL midreset_fs got=%0b want=1", fs); end
        for (int k = 0; k < FT; k++) begin
            if (k > 0) next_cycle();
            e_vec = expect_at(n);
            a_vec = observed();
            total++;
            if (a_vec !== e_vec) begin
                bad++;
                $display("FAIL midreset_scan n=%0d got=%h want=%h", n, a_vec, e_vec);
            end
        end
        $display("test_reset_mid: restarted frame scanned");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_latency();
        test_mode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_scan_engine.md
VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter ADDR_W, default 19, frame-buffer address width.
REQ-006 SHALL have parameter MEM_LAT, default 2, clocks from oAddr to matching iPixel (image memory plus colour table), range 1..8.
REQ-007 SHALL have parameters MODE_W, default 3, and DATA_W, default 24 (packed B,G,R, 8 bits each at default).
REQ-008 SHALL have port iVGA_CLK, input, 1, pixel clock; one clock, synchronous active-low reset.
REQ-009 SHALL have port iRST_n, input, 1, synchronous active-low reset.
REQ-010 SHALL have port iModeReq, input, MODE_W, requested screen mode.
REQ-011 SHALL have port oMode, output, MODE_W, screen mode in effect for the current frame.
REQ-012 SHALL have ports oAddr (output, ADDR_W, pixel read address) and oAddrValid (output, 1, address is for an active pixel).
REQ-013 SHALL have port iPixel, input, DATA_W, colour returned MEM_LAT clocks after oAddr.
REQ-014 SHALL have ports oHS, oVS, oBLANK_n, output, 1 each, active-low syncs and blank aligned to oRGB.
REQ-015 SHALL have port oRGB, output, DATA_W, pixel colour.
REQ-016 SHALL have ports oFrameStart and oSnapshot, output, 1 each, single-clock pulses.

Function
REQ-017 Horizontal counter h SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H terms) and wrap to 0; vertical counter v SHALL advance on the h wrap, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-018 Active region SHALL be h<H_ACTIVE and v<V_ACTIVE; raw HS low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); raw VS low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-019 oAddr SHALL be 0 at h=0,v=0, increment by 1 after each active pixel, and hold during blanking, giving v*H_ACTIVE+h for active pixels without a multiplier.
REQ-020 oAddrValid SHALL equal the raw active flag in the same cycle as oAddr.
REQ-021 Raw HS, VS and active SHALL be delayed by exactly MEM_LAT+1 clocks through a shift pipeline, then driven on oHS, oVS and oBLANK_n.
REQ-022 oRGB SHALL register iPixel when the delayed active flag is 1 and SHALL be 0 otherwise, giving total latency MEM_LAT+1 from oAddr to oRGB.
REQ-023 oMode SHALL load iModeReq only in the cycle with h=0,v=0; changes to iModeReq at any other time SHALL have no effect until the next frame start.
REQ-024 oFrameStart SHALL pulse for one clock when h=0,v=0.
REQ-025 oSnapshot SHALL pulse for one clock when h=0,v=V_ACTIVE (vblank entry), so the game state can be latched without tearing.
REQ-026 oFrameStart and oSnapshot SHALL be undelayed; they are aligned to the counters, not to oRGB.

Reset
REQ-027 While iRST_n=0 at a clock edge: h=0, v=0, oAddr=0, oAddrValid=0, oMode=0, oHS=1, oVS=1, oBLANK_n=0, oRGB=0, pulses=0, delay pipeline flushed to inactive (HS=1, VS=1, active=0).
REQ-028 Release mid-frame SHALL restart at h=0,v=0, with the first frame start in the first cycle after release.

Structure
REQ-029 The default timing constants, the H_TOTAL/V_TOTAL derivation and the mode encoding SHALL live in shared package vga_pkg.
REQ-030 The MEM_LAT+1 sync and blank delay SHALL be a sub-module vga_delay_line, parametrised in width and depth.
REQ-031 Elaboration SHALL fail if H_ACTIVE*V_ACTIVE exceeds 2^ADDR_W.

Verification
REQ-032 After reset release, count clocks between oHS falling edges -> 800; count oHS pulses between oVS falling edges -> 525; oVS low for 2 lines.
REQ-033 Scoreboard iPixel = f(oAddr) delayed MEM_LAT -> oRGB equals f(v*640+h) for every active pixel, 0 when oBLANK_n=0, and the last address is 307199.
REQ-034 iModeReq 1->5 at h=100,v=200 -> oMode stays 1 until the next frame start, then 5.
REQ-035 Reset asserted at h=300,v=250 for 3 clocks -> all outputs at reset values, next oFrameStart one clock after release.
REQ-036 MEM_LAT=1 vs 4 builds -> oBLANK_n rises 2 vs 5 clocks after the first oAddrValid.
REQ-037 Small timing H_ACTIVE=8,V_ACTIVE=4 -> oSnapshot exactly once per frame at v=4,h=0, and oAddr wraps 31->0.
